plle2_status_uart: RTL

Downstream consumer of the PLLE2 tester outputs (LOCKED flag and per-output counter MSBs) on the Basys3 minitest. Periodically, and on every LOCKED change, it snapshots the status and transmits it as a 5-character ASCII line over the board's UART TX pin. Hardware runs can then be logged from a host terminal instead of being read off the LEDs. Self-contained: owns its 2-FF input synchronisers, report timer, frame sequencer and 8N1 serialiser.

---
 rtl/plle2_status_uart.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/plle2_status_uart.sv
// plle2_status_uart
//
// Reports the PLLE2 tester status over the board's UART TX pin so that a
// hardware run can be logged from a host terminal. A report goes out after
// each wrap of a free-running report timer, on every change of LOCKED, and
// on an explicit I_TRIG request. Each report is a five-character line:
// 'L' or 'U', two uppercase hex digits of the counter bits, then CR LF.
// Bytes are sent 8N1, LSB first, with no gap between bytes.
//
// Ports
//   CLK       system clock, all logic on the rising edge
//   RST       synchronous active-high reset; aborts any frame in flight
//   I_LOCKED  PLL LOCKED flag, asynchronous to CLK
//   I_CNT     tester counter bits, asynchronous to CLK
//   I_TRIG    single-cycle synchronous request for an extra report
//   O_TX      UART transmit line, idle high
//   O_BUSY    high while a frame is on the line
module plle2_status_uart #(
    parameter int BAUD_DIV      = 868,
    parameter int REPORT_PERIOD = 10000000,
    parameter int WIDTH         = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             I_LOCKED,
    input  logic [WIDTH-1:0] I_CNT,
    input  logic             I_TRIG,
    output logic             O_TX,
    output logic             O_BUSY
);

    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int TW = (REPORT_PERIOD > 1) ? $clog2(REPORT_PERIOD) : 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // Synchroniser and edge-detect registers
    logic             lock_meta_q, lock_meta_d;
    logic             lock_s_q,    lock_s_d;
    logic             lock_d_q,    lock_d_d;
    logic             lock_chg_q,  lock_chg_d;
    logic [WIDTH-1:0] cnt_meta_q,  cnt_meta_d;
    logic [WIDTH-1:0] cnt_s_q,     cnt_s_d;

    // Report scheduling
    logic [TW-1:0]    timer_q,     timer_d;
    logic             pending_q,   pending_d;
    logic             tick;

    // Frame sequencer and serialiser
    state_t           state_q,     state_d;
    logic [BW-1:0]    baud_q,      baud_d;
    logic [2:0]       bit_idx_q,   bit_idx_d;
    logic [2:0]       byte_idx_q,  byte_idx_d;
    logic             snap_lock_q, snap_lock_d;
    logic [7:0]       snap_cnt_q,  snap_cnt_d;
    logic             tx_q,        tx_d;
    logic             busy_q,      busy_d;
    logic             frame_start;
    logic             baud_end;
    logic [7:0]       cur_byte;

    assign O_TX   = tx_q;
    assign O_BUSY = busy_q;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

    // Two-flop synchronisers. The LOCKED change pulse is itself registered,
    // so a LOCKED edge reaches the pending flag one cycle after it is seen
    // in the synchronised domain.
    always_comb begin
        lock_meta_d = I_LOCKED;
        lock_s_d    = lock_meta_q;
        lock_d_d    = lock_s_q;
        lock_chg_d  = lock_s_q ^ lock_d_q;
        cnt_meta_d  = I_CNT;
        cnt_s_d     = cnt_meta_q;
    end

    // Free-running report timer; it keeps counting while frames are sent.
    assign tick = (timer_q == TW'(REPORT_PERIOD - 1));

    always_comb begin
        timer_d = timer_q + TW'(1);
        if (tick) begin
            timer_d = '0;
        end
    end

    // Any number of report requests collapse into a single pending bit.
    // A request on the same cycle a frame starts must survive, so the set
    // is applied after the clear.
    always_comb begin
        pending_d = pending_q;
        if (frame_start) begin
            pending_d = 1'b0;
        end
        if (tick || lock_chg_q || I_TRIG) begin
            pending_d = 1'b1;
        end
    end

    // Character for the byte currently being shifted out, built from the
    // snapshot taken when the frame started.
    always_comb begin
        cur_byte = 8'h0A;
        case (byte_idx_q)
            3'd0:    cur_byte = snap_lock_q ? 8'h4C : 8'h55;
            3'd1:    cur_byte = hex_ascii(snap_cnt_q[7:4]);
            3'd2:    cur_byte = hex_ascii(snap_cnt_q[3:0]);
            3'd3:    cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
        endcase
    end

    assign baud_end = (baud_q == BW'(BAUD_DIV - 1));

    // Frame sequencer. tx is registered and loaded with the value of the
    // next bit on the edge that ends the current one, so every bit lasts
    // exactly BAUD_DIV cycles and the stop bit of one byte runs straight
    // into the start bit of the next.
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_idx_d   = bit_idx_q;
        byte_idx_d  = byte_idx_q;
        snap_lock_d = snap_lock_q;
        snap_cnt_d  = snap_cnt_q;
        tx_d        = tx_q;
        busy_d      = busy_q;
        frame_start = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (pending_q) begin
                    frame_start = 1'b1;
                    state_d     = START;
                    baud_d      = '0;
                    bit_idx_d   = '0;
                    byte_idx_d  = '0;
                    snap_lock_d = lock_s_q;
                    snap_cnt_d  = 8'(cnt_s_q);
                    tx_d        = 1'b0;
                    busy_d      = 1'b1;
                end
            end

            START: begin
                if (baud_end) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                    tx_d      = cur_byte[0];
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end

            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = cur_byte[bit_idx_q + 3'd1];
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end

            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (byte_idx_q < 3'd4) begin
                        byte_idx_d = byte_idx_q + 3'd1;
                        state_d    = START;
                        tx_d       = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end

            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // All state registers; reset drops any frame in flight and any pending
    // request so nothing partial resumes afterwards.
    always_ff @(posedge CLK) begin
        if (RST) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            lock_d_q    <= 1'b0;
            lock_chg_q  <= 1'b0;
            cnt_meta_q  <= '0;
            cnt_s_q     <= '0;
            timer_q     <= '0;
            pending_q   <= 1'b0;
            state_q     <= IDLE;
            baud_q      <= '0;
            bit_idx_q   <= '0;
            byte_idx_q  <= '0;
            snap_lock_q <= 1'b0;
            snap_cnt_q  <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            lock_meta_q <= lock_meta_d;
            lock_s_q    <= lock_s_d;
            lock_d_q    <= lock_d_d;
            lock_chg_q  <= lock_chg_d;
            cnt_meta_q  <= cnt_meta_d;
            cnt_s_q     <= cnt_s_d;
            timer_q     <= timer_d;
            pending_q   <= pending_d;
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_idx_q   <= bit_idx_d;
            byte_idx_q  <= byte_idx_d;
            snap_lock_q <= snap_lock_d;
            snap_cnt_q  <= snap_cnt_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
        end
    end

endmodule
